// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM encoding and a
// constant clog2 used to size shift amounts and counters.
package alu_pkg;

    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_SUB     = 3'b001;
    localparam logic [2:0] OP_NANDNOR = 3'b010;
    localparam logic [2:0] OP_XORX    = 3'b011;
    localparam logic [2:0] OP_ACC     = 3'b100;
    localparam logic [2:0] OP_MUL     = 3'b101;
    localparam logic [2:0] OP_ROL     = 3'b110;
    localparam logic [2:0] OP_CLR     = 3'b111;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/shift_add_mul.sv
// W-cycle shift-add multiplier. product is the next accumulator value so the
// parent can register it in step with the engine's own accumulator.
module shift_add_mul
    import alu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = (clog2(W) < 1) ? 1 : clog2(W);

    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           last_step;

    assign last_step = busy_q && (cnt_q == CW'(W - 1));

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (busy_q) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = last_step ? '0 : cnt_q + CW'(1);
            busy_d   = !last_step;
        end else if (start) begin
            acc_d    = '0;
            mcand_d  = {{W{1'b0}}, a};
            mplier_d = b;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = last_step;
    assign product = acc_d;

endmodule

// File: rtl/seq_alu_accum.sv
// Registered ALU with accumulator, rotate and multi-cycle multiply.
// Handshake: a request is taken on any rising edge with in_valid && in_ready; out_valid pulses one cycle per completed request.
module seq_alu_accum
    import alu_pkg::*;
#(
    parameter int W      = 4,
    parameter int SW_REG = 0
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] result,
    output logic           out_valid,
    output logic           zero,
    output logic [0:0]     dbg_state
);

    localparam int SHW = clog2(2 * W);
    localparam int RW  = W + 1;

    // Operands are captured at acceptance in either SW_REG setting: the
    // multiplier latches its own copy and single-cycle ops land in result.
    if (W < 2 || W > 16 || SW_REG < 0 || SW_REG > 1) begin : g_bad_param
        $error("seq_alu_accum: W must be 2..16 and SW_REG 0 or 1");
    end

    logic [0:0]     state_q, state_d;
    logic [2*W-1:0] result_q, result_d;
    logic           out_valid_q, out_valid_d;
    logic           zero_q, zero_d;

    logic           accept;
    logic           mul_start;
    logic           mul_busy;
    logic           mul_done;
    logic [2*W-1:0] mul_product;

    logic [W:0]     rot_mod;
    logic [SHW-1:0] rot_amt;
    logic [4*W-1:0] rot_dbl;
    logic [2*W-1:0] rol_res;

    assign in_ready  = (state_q == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL);

    assign rot_mod = {1'b0, b} % RW'(2 * W);
    assign rot_amt = rot_mod[SHW-1:0];
    assign rot_dbl = {result_q, result_q} << rot_amt;
    assign rol_res = rot_dbl[4*W-1:2*W];

    shift_add_mul #(.W(W)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        out_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    case (op)
                        OP_ADD:     result_d = {{W{1'b0}}, a} + {{W{1'b0}}, b};
                        OP_SUB:     result_d = {{W{1'b0}}, a} - {{W{1'b0}}, b};
                        OP_NANDNOR: result_d = {~(a | b), ~(a & b)};
                        OP_XORX:    result_d = {a ^ b, ~(a ^ b)};
                        OP_ACC:     result_d = result_q + {{W{1'b0}}, a};
                        OP_MUL: begin
                            result_d    = '0;
                            state_d     = ST_MUL;
                            out_valid_d = 1'b0;
                        end
                        OP_ROL:     result_d = rol_res;
                        default:    result_d = '0;
                    endcase
                end
            end
            default: begin
                // Intermediate partial products are shown on result as they form.
                result_d = mul_product;
                if (mul_done || !mul_busy) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                end
            end
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            zero_q      <= zero_d;
        end
    end

    assign result    = result_q;
    assign out_valid = out_valid_q;
    assign zero      = zero_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_alu_accum.sv
// Directed bench for seq_alu_accum at W=4 with hand-computed expected values.
module tb_seq_alu_accum;
    import alu_pkg::*;

    localparam int W = 4;

    logic           clock;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] result;
    logic           out_valid;
    logic           zero;
    logic [0:0]     dbg_state;

    int total  = 0;
    int passed = 0;

    seq_alu_accum #(.W(W), .SW_REG(0)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .result    (result),
        .out_valid (out_valid),
        .zero      (zero),
        .dbg_state (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        op       = o;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    logic [7:0] mul_ff_steps [3];

    initial begin
        mul_ff_steps[0] = 8'h0F;
        mul_ff_steps[1] = 8'h2D;
        mul_ff_steps[2] = 8'h69;

        reset    = 1'b1;
        in_valid = 1'b0;
        op       = OP_ADD;
        a        = '0;
        b        = '0;
        #12;
        chk("rst_result", 16'(result), 16'h00);
        chk("rst_zero", 16'(zero), 16'h1);
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_in_ready", 16'(in_ready), 16'h1);
        chk("rst_state", 16'(dbg_state), 16'(ST_IDLE));
        @(negedge clock);
        reset = 1'b0;

        issue(OP_ADD, 4'h9, 4'h8);
        chk("add_result", 16'(result), 16'h11);
        chk("add_out_valid", 16'(out_valid), 16'h1);
        chk("add_zero", 16'(zero), 16'h0);
        tick();
        chk("add_pulse_end", 16'(out_valid), 16'h0);

        issue(OP_NANDNOR, 4'hA, 4'h5);
        chk("nandnor_result", 16'(result), 16'h0F);
        issue(OP_XORX, 4'hA, 4'h5);
        chk("xorx_result", 16'(result), 16'hF0);

        issue(OP_CLR, 4'h3, 4'h3);
        chk("clr_result", 16'(result), 16'h00);
        chk("clr_zero", 16'(zero), 16'h1);

        op       = OP_ACC;
        a        = 4'h5;
        in_valid = 1'b1;
        tick();
        chk("acc1_result", 16'(result), 16'h05);
        chk("acc1_out_valid", 16'(out_valid), 16'h1);
        tick();
        chk("acc2_result", 16'(result), 16'h0A);
        chk("acc2_out_valid", 16'(out_valid), 16'h1);
        tick();
        chk("acc3_result", 16'(result), 16'h0F);
        chk("acc3_out_valid", 16'(out_valid), 16'h1);
        in_valid = 1'b0;
        tick();
        chk("acc_pulse_end", 16'(out_valid), 16'h0);

        issue(OP_SUB, 4'h0, 4'h2);
        chk("sub_wrap_result", 16'(result), 16'hFE);
        issue(OP_ACC, 4'h3, 4'h0);
        chk("acc_wrap_result", 16'(result), 16'h01);
        chk("acc_wrap_zero", 16'(zero), 16'h0);

        issue(OP_MUL, 4'hF, 4'hF);
        chk("mul_ff_busy0_ready", 16'(in_ready), 16'h0);
        chk("mul_ff_busy0_result", 16'(result), 16'h00);
        chk("mul_ff_busy0_state", 16'(dbg_state), 16'(ST_MUL));
        op       = OP_ADD;
        a        = 4'h1;
        b        = 4'h1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mul_ff_step%0d_result", i + 1), 16'(result), 16'(mul_ff_steps[i]));
            chk($sformatf("mul_ff_step%0d_ready", i + 1), 16'(in_ready), 16'h0);
            chk($sformatf("mul_ff_step%0d_out_valid", i + 1), 16'(out_valid), 16'h0);
        end
        tick();
        in_valid = 1'b0;
        chk("mul_ff_final_result", 16'(result), 16'hE1);
        chk("mul_ff_final_out_valid", 16'(out_valid), 16'h1);
        chk("mul_ff_final_ready", 16'(in_ready), 16'h1);
        tick();
        chk("mul_ff_ignored_add", 16'(result), 16'hE1);
        chk("mul_ff_pulse_end", 16'(out_valid), 16'h0);

        issue(OP_MUL, 4'h3, 4'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mul_x0_step%0d_zero", i + 1), 16'(zero), 16'h1);
        end
        tick();
        chk("mul_x0_result", 16'(result), 16'h00);
        chk("mul_x0_zero", 16'(zero), 16'h1);
        chk("mul_x0_out_valid", 16'(out_valid), 16'h1);

        issue(OP_ADD, 4'h9, 4'hF);
        chk("rol_setup_result", 16'(result), 16'h18);
        issue(OP_ROL, 4'h0, 4'h4);
        chk("rol4_result", 16'(result), 16'h81);
        issue(OP_ROL, 4'h0, 4'h1);
        chk("rol1_result", 16'(result), 16'h03);
        issue(OP_ROL, 4'h0, 4'h7);
        chk("rol7_result", 16'(result), 16'h81);
        tick();
        issue(OP_ROL, 4'h0, 4'h8);
        chk("rol8_result", 16'(result), 16'h81);
        chk("rol8_out_valid", 16'(out_valid), 16'h1);
        tick();
        issue(OP_ROL, 4'h0, 4'h0);
        chk("rol0_result", 16'(result), 16'h81);
        chk("rol0_out_valid", 16'(out_valid), 16'h1);
        issue(OP_ROL, 4'h0, 4'h9);
        chk("rol9_result", 16'(result), 16'h03);

        issue(OP_MUL, 4'h7, 4'h7);
        tick();
        chk("mul77_step1_result", 16'(result), 16'h07);
        tick();
        chk("mul77_step2_result", 16'(result), 16'h15);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_result", 16'(result), 16'h00);
        chk("async_rst_ready", 16'(in_ready), 16'h1);
        chk("async_rst_zero", 16'(zero), 16'h1);
        chk("async_rst_state", 16'(dbg_state), 16'(ST_IDLE));
        tick();
        tick();
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("post_rst%0d_out_valid", i), 16'(out_valid), 16'h0);
            chk($sformatf("post_rst%0d_result", i), 16'(result), 16'h00);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
